// File: rtl/display_pkg.sv
// display_pkg
// Shared definitions for the display scan path (scheduler and segment decoder).
//   DIGITS     : number of scanned digit positions
//   NIB_W      : width of one hex digit slice of the display value
//   PWM_STEPS  : brightness steps per ON window
//   AN_OFF     : anode vector with every (active-low) anode released
//   scan_state_e : slot FSM encoding (ST_BLANK, ST_ON)
//   slot_len() : clocks in one digit slot for a given blank/step setting
package display_pkg;

    localparam int DIGITS    = 8;
    localparam int NIB_W     = 4;
    localparam int PWM_STEPS = 16;

    localparam logic [DIGITS-1:0] AN_OFF = 8'hFF;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_e;

    function automatic int slot_len(input int blank_cycles, input int step_cycles);
        return blank_cycles + PWM_STEPS * step_cycles;
    endfunction

endpackage

// File: rtl/display_scan_scheduler_if.sv
// display_scan_scheduler_if
// Bundles the value/control inputs and the anode/digit outputs of the scan
// scheduler.
//   value        : hex value, nibble i shown on digit i (digit 0 rightmost)
//   digit_enable : per-digit enable, 0 keeps the digit dark
//   lz_blank     : 1 suppresses leading zeros
//   brightness   : PWM duty in sixteenths
//   an           : active-low anode selects
//   hex_digit    : nibble for the segment decoder
//   frame_start  : one-cycle pulse on the first clock of digit 0's slot
// master = the datapath side driving the value, slave = the scheduler.
interface display_scan_scheduler_if;
    import display_pkg::*;

    logic [NIB_W*DIGITS-1:0] value;
    logic [DIGITS-1:0]       digit_enable;
    logic                    lz_blank;
    logic [3:0]              brightness;
    logic [DIGITS-1:0]       an;
    logic [NIB_W-1:0]        hex_digit;
    logic                    frame_start;

    modport master (
        output value, digit_enable, lz_blank, brightness,
        input  an, hex_digit, frame_start
    );

    modport slave (
        input  value, digit_enable, lz_blank, brightness,
        output an, hex_digit, frame_start
    );

endinterface

// File: rtl/display_scan_scheduler_slot_timer.sv
// slot_timer
// Owns the per-slot BLANK/ON sequencing: a dead-time counter, a step
// prescaler and the 16-step PWM index.
//   clk, reset   : system clock, synchronous active-high reset
//   in_on_o      : slot is in its ON window
//   step_o       : current PWM step index (0..15) while in ON
//   slot_start_o : this cycle is the first BLANK cycle of a slot
//   slot_end_o   : this cycle is the last cycle of step 15
module slot_timer
    import display_pkg::*;
#(
    parameter int BLANK_CYCLES = 100,
    parameter int STEP_CYCLES  = 390
) (
    input  logic       clk,
    input  logic       reset,
    output logic       in_on_o,
    output logic [3:0] step_o,
    output logic       slot_start_o,
    output logic       slot_end_o
);

    localparam int BLANK_W = $clog2(BLANK_CYCLES + 1);
    localparam int PRE_W   = $clog2(STEP_CYCLES + 1);

    localparam logic [BLANK_W-1:0] BLANK_LAST = BLANK_W'(BLANK_CYCLES - 1);
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(STEP_CYCLES - 1);
    localparam logic [3:0]         STEP_LAST  = 4'(PWM_STEPS - 1);

    scan_state_e        state_q, state_d;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic [PRE_W-1:0]   pre_q,   pre_d;
    logic [3:0]         step_q,  step_d;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_BLANK;
            blank_q <= '0;
            pre_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            blank_q <= blank_d;
            pre_q   <= pre_d;
            step_q  <= step_d;
        end
    end

    // NOTE: every signal written here gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        state_d    = state_q;
        blank_d    = blank_q;
        pre_d      = pre_q;
        step_d     = step_q;
        slot_end_o = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (blank_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    blank_d = '0;
                    pre_d   = '0;
                    step_d  = '0;
                end else begin
                    blank_d = blank_q + BLANK_W'(1);
                end
            end
            ST_ON: begin
                if (pre_q == PRE_LAST) begin
                    pre_d = '0;
                    if (step_q == STEP_LAST) begin
                        slot_end_o = 1'b1;
                        state_d    = ST_BLANK;
                        step_d     = '0;
                    end else begin
                        step_d = step_q + 4'd1;
                    end
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            default: state_d = ST_BLANK;
        endcase
    end

    assign in_on_o      = (state_q == ST_ON);
    assign step_o       = step_q;
    assign slot_start_o = (state_q == ST_BLANK) && (blank_q == '0);

endmodule

// File: rtl/display_scan_scheduler.sv
// display_scan_scheduler
// Time-multiplexes an 8-digit common-anode 7-segment display with per-slot
// dead-time, 4-bit PWM brightness, leading-zero blanking and a once-per-frame
// snapshot of the displayed value.
//   clk, reset : system clock, synchronous active-high reset
//   bus        : slave side of display_scan_scheduler_if (value/enables/
//                lz_blank/brightness in, an/hex_digit/frame_start out)
// The slot timer runs one cycle ahead of the registered outputs: the timer
// state seen this cycle determines what an/hex_digit/frame_start show next.
module display_scan_scheduler
    import display_pkg::*;
#(
    parameter int BLANK_CYCLES = 100,
    parameter int STEP_CYCLES  = 390
) (
    input  logic                       clk,
    input  logic                       reset,
    display_scan_scheduler_if.slave    bus
);

    localparam int                 IDX_W    = $clog2(DIGITS);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(DIGITS - 1);

    logic       in_on, slot_start, slot_end;
    logic [3:0] step;

    slot_timer #(
        .BLANK_CYCLES (BLANK_CYCLES),
        .STEP_CYCLES  (STEP_CYCLES)
    ) u_slot_timer (
        .clk          (clk),
        .reset        (reset),
        .in_on_o      (in_on),
        .step_o       (step),
        .slot_start_o (slot_start),
        .slot_end_o   (slot_end)
    );

    logic [IDX_W-1:0]        digit_idx_q, digit_idx_d;
    logic [NIB_W*DIGITS-1:0] value_q,     value_d;
    logic [DIGITS-1:0]       en_q,        en_d;
    logic                    lz_q,        lz_d;
    logic [DIGITS-1:0]       mask_q,      mask_d;
    logic [3:0]              bright_q,    bright_d;
    logic [DIGITS-1:0]       an_q,        an_d;
    logic [NIB_W-1:0]        hex_q,       hex_d;
    logic                    fs_q,        fs_d;
    logic                    frame_snap;

    // Visibility: enabled, and either LZ suppression is off, the digit is at
    // or below the most significant enabled nonzero nibble, or it is digit 0.
    function automatic logic [DIGITS-1:0] vis_mask(
        input logic [NIB_W*DIGITS-1:0] v,
        input logic [DIGITS-1:0]       en,
        input logic                    lz
    );
        int                msd;
        logic [DIGITS-1:0] vis;
        msd = 0;
        for (int i = 0; i < DIGITS; i++) begin
            if (en[i] && (v[NIB_W*i +: NIB_W] != '0)) msd = i;
        end
        for (int i = 0; i < DIGITS; i++) begin
            vis[i] = en[i] && (!lz || (i <= msd) || (i == 0));
        end
        return vis;
    endfunction

    // Snapshot point: the first BLANK cycle of digit 0's slot.
    assign frame_snap = slot_start && (digit_idx_q == '0);

    always_comb begin
        digit_idx_d = digit_idx_q;
        value_d     = value_q;
        en_d        = en_q;
        lz_d        = lz_q;
        mask_d      = mask_q;
        bright_d    = bright_q;

        if (slot_end) digit_idx_d = (digit_idx_q == LAST_IDX) ? '0 : digit_idx_q + IDX_W'(1);

        if (frame_snap) begin
            value_d = bus.value;
            en_d    = bus.digit_enable;
            lz_d    = bus.lz_blank;
            mask_d  = vis_mask(bus.value, bus.digit_enable, bus.lz_blank);
        end

        if (slot_start) bright_d = bus.brightness;

        // Uses the freshly captured value so the digit-0 nibble is already
        // correct on the frame_start cycle.
        hex_d = value_d[NIB_W*digit_idx_q +: NIB_W];
        fs_d  = frame_snap;

        an_d = AN_OFF;
        if (in_on && (step < bright_q) && mask_q[digit_idx_q]) an_d[digit_idx_q] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_idx_q <= '0;
            value_q     <= '0;
            en_q        <= '0;
            lz_q        <= 1'b0;
            mask_q      <= '0;
            bright_q    <= '0;
            an_q        <= AN_OFF;
            hex_q       <= '0;
            fs_q        <= 1'b0;
        end else begin
            digit_idx_q <= digit_idx_d;
            value_q     <= value_d;
            en_q        <= en_d;
            lz_q        <= lz_d;
            mask_q      <= mask_d;
            bright_q    <= bright_d;
            an_q        <= an_d;
            hex_q       <= hex_d;
            fs_q        <= fs_d;
        end
    end

    assign bus.an          = an_q;
    assign bus.hex_digit   = hex_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_display_scan_scheduler.sv
// tb_display_scan_scheduler
// Scoreboard bench for display_scan_scheduler with BLANK_CYCLES=2,
// STEP_CYCLES=2 (34-clock slots, 272-clock frames). A reference model
// derives, for every slot, what the display must show from the display rules
// and pushes it into a queue; an independent monitor summarises what the DUT
// actually drove over each slot and compares at the slot's last clock.
module tb_display_scan_scheduler;
    import display_pkg::*;

    localparam int BLANK = 2;
    localparam int STEP  = 2;
    localparam int SLOT  = slot_len(BLANK, STEP);
    localparam int FRAME = SLOT * DIGITS;

    typedef struct packed {
        logic       fs_at0;
        logic       fs_other;
        logic [3:0] hex;
        logic       hex_stable;
        logic [5:0] low_count;
        logic [5:0] low_first;
        logic [5:0] low_last;
        logic [7:0] low_pat;
        logic       bad_pat;
    } obs_t;

    typedef struct {
        int   digit;
        obs_t exp;
    } sb_item_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    display_scan_scheduler_if bus ();

    display_scan_scheduler #(
        .BLANK_CYCLES (BLANK),
        .STEP_CYCLES  (STEP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    sb_item_t    sb_q[$];
    int          cyc       = 0;   // index of the next non-reset clock edge
    int          last_edge = 0;   // index of the most recent non-reset edge
    int          edge_kind = 0;   // 0 none yet, 1 reset edge, 2 running edge
    logic [31:0] m_val;
    logic [7:0]  m_en;
    logic        m_lz;
    int          m_d, m_b;
    bit          m_lit;
    obs_t        m_e;
    sb_item_t    m_it;

    // True if some enabled digit at position d or higher holds a nonzero nibble.
    function automatic bit upper_nonzero(input int d);
        for (int i = d; i < DIGITS; i++) begin
            if (m_en[i] && (m_val[4*i +: 4] != 4'h0)) return 1'b1;
        end
        return 1'b0;
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            sb_q.delete();
            cyc       = 0;
            edge_kind = 1;
        end else begin
            if (cyc % FRAME == 0) begin
                m_val = bus.value;
                m_en  = bus.digit_enable;
                m_lz  = bus.lz_blank;
            end
            if (cyc % SLOT == 0) begin
                m_d   = (cyc / SLOT) % DIGITS;
                m_b   = int'(bus.brightness);
                m_lit = m_en[m_d] && ((m_d == 0) || !m_lz || upper_nonzero(m_d));
                m_e            = '0;
                m_e.fs_at0     = (m_d == 0);
                m_e.hex        = m_val[4*m_d +: 4];
                m_e.hex_stable = 1'b1;
                m_e.low_pat    = 8'hFF;
                if (m_lit && m_b > 0) begin
                    m_e.low_count = 6'(STEP * m_b);
                    m_e.low_first = 6'(BLANK);
                    m_e.low_last  = 6'(BLANK + STEP * m_b - 1);
                    m_e.low_pat   = ~(8'h01 << m_d);
                end
                m_it.digit = m_d;
                m_it.exp   = m_e;
                sb_q.push_back(m_it);
            end
            last_edge = cyc;
            cyc++;
            edge_kind = 2;
        end
    end

    // ---------------- monitor ----------------
    obs_t     acc;
    int       sc;
    sb_item_t mon_it;

    initial forever begin
        @(negedge clk);
        if (edge_kind == 1) begin
            check("reset_an",  64'(bus.an),          64'(AN_OFF));
            check("reset_hex", 64'(bus.hex_digit),   64'(0));
            check("reset_fs",  64'(bus.frame_start), 64'(0));
        end else if (edge_kind == 2) begin
            sc = last_edge % SLOT;
            if (sc == 0) begin
                acc            = '0;
                acc.fs_at0     = bus.frame_start;
                acc.hex        = bus.hex_digit;
                acc.hex_stable = 1'b1;
                acc.low_pat    = 8'hFF;
            end else begin
                if (bus.frame_start !== 1'b0) acc.fs_other = 1'b1;
                if (bus.hex_digit !== acc.hex) acc.hex_stable = 1'b0;
            end
            if (bus.an !== AN_OFF) begin
                if ($countones(~bus.an) != 1) acc.bad_pat = 1'b1;
                if (acc.low_count == 0) begin
                    acc.low_first = 6'(sc);
                    acc.low_pat   = bus.an;
                end else if (bus.an !== acc.low_pat) begin
                    acc.bad_pat = 1'b1;
                end
                acc.low_last  = 6'(sc);
                acc.low_count = acc.low_count + 6'd1;
            end
            if (sc == SLOT - 1) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty: got slot output with no expectation queued (t=%0t)", $time);
                end else begin
                    mon_it = sb_q.pop_front();
                    check($sformatf("slot_digit%0d", mon_it.digit), 64'(acc), 64'(mon_it.exp));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Waits until the next edge is frame-relative position target.
    task automatic wait_phase(input int target);
        int budget = 0;
        while ((cyc % FRAME) != target && budget < 2 * FRAME) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 2 * FRAME) begin
            total++;
            bad++;
            $display("FAIL wait_phase: got no phase %0d within %0d clocks", target, 2 * FRAME);
        end
    endtask

    initial begin
        logic [31:0] v;
        int          sh;

        bus.value        = 32'h1234_5678;
        bus.digit_enable = 8'hFF;
        bus.lz_blank     = 1'b0;
        bus.brightness   = 4'd15;
        reset            = 1'b1;
        run(3);
        reset = 1'b0;

        // Full brightness walk over all digits.
        run(FRAME + 10);

        // Leading-zero blanking on, then off, for the same value.
        bus.value    = 32'h0000_00A0;
        bus.lz_blank = 1'b1;
        run(2 * FRAME);
        bus.lz_blank = 1'b0;
        run(2 * FRAME);

        // Reduced and zero brightness.
        bus.brightness = 4'd4;
        run(FRAME + 20);
        bus.brightness = 4'd0;
        run(2 * FRAME);

        // Mid-frame value change must not tear the current frame.
        bus.brightness = 4'd15;
        bus.value      = 32'h1111_1111;
        run(2 * FRAME);
        wait_phase(3 * SLOT + 5);
        bus.value = 32'h2222_2222;
        run(2 * FRAME);

        // Sparse enables.
        bus.digit_enable = 8'h05;
        run(2 * FRAME);

        // Reset pulse inside digit 3's ON window.
        bus.digit_enable = 8'hFF;
        bus.value        = 32'h1234_5678;
        run(FRAME);
        wait_phase(3 * SLOT + 10);
        reset = 1'b1;
        @(negedge clk);
        bus.value = 32'h8765_4321;
        reset     = 1'b0;
        run(FRAME + 50);

        // Randomised settings, biased towards leading zeros.
        for (int k = 0; k < 24; k++) begin
            v  = $urandom;
            sh = $urandom_range(0, 32);
            bus.value        = (sh == 32) ? 32'h0 : (v >> sh);
            bus.digit_enable = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
            bus.lz_blank     = 1'($urandom);
            bus.brightness   = 4'($urandom);
            run($urandom_range(30, 400));
        end

        run(SLOT);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/display_scan_scheduler.md
# display_scan_scheduler

Time-multiplexes an 8-digit common-anode 7-segment display from a 32-bit hex value. Sequences anode scanning with per-slot dead-time and 4-bit PWM brightness. Applies leading-zero blanking and snapshots the value once per frame so the display never tears. Sits between the counter datapath and the `seven_segment_decoder`, replacing the fixed 1 kHz `display_control` scan; it runs on the system clock with its own slot timer.

## Interface
- `DIGITS`, 8: number of digit positions scanned.
- `BLANK_CYCLES`, 100: clocks at the start of every slot with all anodes off (anti-ghosting dead-time); must be ≥1.
- `STEP_CYCLES`, 390: clocks per PWM step; ON window = 16 × `STEP_CYCLES`.
- `clk`  in  1  system clock (100 MHz).
- `reset`  in  1  synchronous, active-high reset.
- `value`  in  32  hex value; nibble i drives digit i (digit 0 = rightmost).
- `digit_enable`  in  8  per-digit enable; 0 = digit always dark.
- `lz_blank`  in  1  1 = suppress leading zeros.
- `brightness`  in  4  PWM duty in sixteenths (0 = dark, 15 = 15/16).
- `an`  out  8  anode selects, active-low.
- `hex_digit`  out  4  nibble for the decoder, valid while the corresponding anode is low.
- `frame_start`  out  1  one-cycle pulse on the first clock of digit 0's slot.

## Operation
- Slot = `BLANK_CYCLES` + 16×`STEP_CYCLES` clocks. Frame = `DIGITS` slots, a fixed length regardless of enables or blanking.
- FSM, two states:
  - BLANK: `an` = all ones. After `BLANK_CYCLES` clocks → ON with step counter = 0.
  - ON: step index s counts 0..15, advancing every `STEP_CYCLES` clocks.
  - After the last cycle of step 15, advance `digit_idx` (wrapping `DIGITS`-1 → 0) and return to BLANK.
- Anode drive in ON: `an[digit_idx]` = 0 iff s < brightness_q AND the digit is visible. All other anode bits are 1.
- `brightness_q` is sampled on the first cycle of each slot's BLANK state and is constant through the slot.
- Snapshot: on entering BLANK with `digit_idx` = 0, `value_q` ← `value`, `en_q` ← `digit_enable`, `lz_q` ← `lz_blank`. Simultaneously, the visibility mask is computed from the new values and registered.
- Visibility of digit i = `en_q[i]` AND (NOT `lz_q` OR i ≤ msd OR i = 0).
  - msd = index of the highest nonzero nibble of `value_q` among enabled digits; 0 if none.
  - Digit 0 is never blanked by LZ suppression.
- `hex_digit` = `value_q[4·digit_idx +: 4]` for the whole slot, including BLANK.
- `frame_start` = 1 on the single cycle that enters BLANK with `digit_idx` = 0.

## Timing
- Reset values: `an` = 8'hFF, `hex_digit` = 0, `frame_start` = 0, `digit_idx` = 0, `value_q` = 0, `en_q` = 0, `lz_q` = 0, mask = 0, state = BLANK, all counters 0.
- First cycle after reset deasserts:
  - Entering BLANK with `digit_idx` = 0 → snapshot taken and `frame_start` = 1.
- `an` and `hex_digit` are registered outputs.
  - Anode-on begins exactly `BLANK_CYCLES` clocks after slot start.
  - The anode is off for the final (16 − brightness_q)×`STEP_CYCLES` clocks of the slot.
- Input-change latency:
  - `value`, `digit_enable`, `lz_blank` take effect at the next frame start (≤ one frame).
  - `brightness` takes effect at the next slot start.
- Mid-frame input changes never alter the current frame.
- Reset asserted mid-slot: on the next clock, `an` = 8'hFF and all state returns to reset values.
- `brightness` = 0: `an` stays all ones permanently, but the slot/frame cadence is unchanged.
- `value` = 0 with `lz_blank` = 1: only digit 0 lit (if enabled).
- Never more than one `an` bit low at any cycle.
- At least `BLANK_CYCLES` all-off cycles separate any two different lit digits.

## Structure
- Shared package `display_pkg`: `DIGITS`, `AN_OFF` (8'hFF), state encoding constants (`ST_BLANK`, `ST_ON`), the slot-length helper, and the nibble-slice width (4). Both this block and the decoder use these.
- One sub-module: `slot_timer`, which owns the BLANK/ON FSM, blank counter, step prescaler and step index. It outputs `in_on`, `step`, `slot_start` and `slot_end`.
- The top level holds `digit_idx`, the snapshot registers, the LZ mask logic and the output registers.

## Test plan
Bench parameters: `BLANK_CYCLES`=2, `STEP_CYCLES`=2 (slot = 34 clocks, frame = 272 clocks).
- Reset, `value`=32'h1234_5678, enables 8'hFF, `lz_blank`=0, `brightness`=15 → `frame_start` every 272 clocks. `an` walks FE, FD, FB…7F; each digit low for 30 of 34 clocks, starting at slot clock 2; `hex_digit` = 8, 7, 6…1.
- `value`=32'h0000_00A0, `lz_blank`=1, all enabled → only digits 0 and 1 lit, showing 0 and A. Same value with `lz_blank`=0 → all 8 lit.
- `brightness`=4 → each lit digit low for exactly 8 clocks (slot clocks 2–9). `brightness`=0 → `an` = FF for a whole frame while `frame_start` cadence is unchanged.
- Change `value` mid-frame from 32'h1111_1111 to 32'h2222_2222 → remaining slots still show 1. The first frame_start after the change begins showing 2.
- `digit_enable`=8'h05 → only digits 0 and 2 ever go low; frame still 272 clocks.
- Assert `reset` for 1 clock during digit 3's ON window → `an` = FF on the next clock. Scanning restarts at digit 0 with `frame_start`, and the snapshot is retaken.
